// File: rtl/median_pkg.sv
// -----------------------------------------------------------------------------
// median_pkg
// Shared definitions for the streaming 3x3 median window controller.
//   - Default pixel width and image geometry.
//   - Controller state encoding.
//   - Window tap indexing: tap k = 3*row + col, row 0 is the oldest line,
//     col 0 is the oldest column.
// -----------------------------------------------------------------------------
package median_pkg;

    localparam int DATA_SIZE_DEF  = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    localparam int WIN_DIM  = 3;
    localparam int NUM_TAPS = WIN_DIM * WIN_DIM;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

    function automatic int tap_idx(input int row, input int col);
        return WIN_DIM * row + col;
    endfunction

endpackage

// File: rtl/median_line_buffer.sv
// -----------------------------------------------------------------------------
// median_line_buffer
// Single-port line memory, one word per pixel column. The read port is
// combinational at the current address, so the old word is observed in the
// same cycle the new word is written (read-before-write).
// Ports:
//   clk_i    clock, rising edge
//   we_i     write enable
//   addr_i   column address (read and write)
//   wdata_i  word to store at addr_i
//   rdata_o  word currently held at addr_i
// -----------------------------------------------------------------------------
module median_line_buffer #(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 640,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    output logic [DATA_SIZE-1:0] rdata_o
);

    // Contents are deliberately not reset; stale words are gated downstream.
    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/median_window_ctrl.sv
// -----------------------------------------------------------------------------
// median_window_ctrl
// Sequences an external combinational 3x3 median network over a raster pixel
// stream. Two line buffers plus a 3x3 register window present the taps; the
// median result is registered and emitted once per fully-interior window.
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous reset, active low
//   in_valid_i    input pixel valid
//   in_ready_o    input pixel accepted when in_valid_i && in_ready_o
//   in_data_i     input pixel
//   in_sof_i      marks pixel (0,0) of a frame
//   win_taps_o    window taps to the median core, tap k at [k*DATA_SIZE +: DATA_SIZE]
//   med_result_i  combinational median of win_taps_o
//   out_valid_o   filtered pixel valid
//   out_ready_i   sink accepts when out_valid_o && out_ready_i
//   out_data_o    filtered pixel
//   out_sof_o     first output of a frame
//   out_eol_o     last output of an output line
//   frame_done_o  one-cycle pulse once the last output of a frame has left
//   busy_o        controller not idle
// -----------------------------------------------------------------------------
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DATA_SIZE-1:0]          in_data_i,
    input  logic                          in_sof_i,
    output logic [NUM_TAPS*DATA_SIZE-1:0] win_taps_o,
    input  logic [DATA_SIZE-1:0]          med_result_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_SIZE-1:0]          out_data_o,
    output logic                          out_sof_o,
    output logic                          out_eol_o,
    output logic                          frame_done_o,
    output logic                          busy_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_e state_q, state_d;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic [DATA_SIZE-1:0] taps_q [NUM_TAPS];
    logic                 win_vld_q, win_sof_q, win_eol_q;

    logic                 out_valid_q, out_sof_q, out_eol_q;
    logic [DATA_SIZE-1:0] out_data_q;

    logic                 advance;
    logic                 in_ready;
    logic                 accept;
    logic                 restart;
    logic                 store;
    logic                 win_ok;
    logic [CW-1:0]        pos_col;
    logic [RW-1:0]        pos_row;
    logic [DATA_SIZE-1:0] lb0_rdata, lb1_rdata;

    // The whole pipeline moves only when the output register can take a word.
    assign advance = !out_valid_q || out_ready_i;
    assign accept  = in_valid_i && in_ready;

    // An sof pixel always restarts the raster; in IDLE every other pixel is
    // accepted but dropped without touching buffers, window or counters.
    assign restart = accept && in_sof_i;
    assign store   = accept && ((state_q != IDLE) || in_sof_i);
    assign pos_col = restart ? '0 : col_q;
    assign pos_row = restart ? '0 : row_q;

    // A window is interior once two full lines and two columns are behind it.
    assign win_ok  = store && !in_sof_i && (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);

    // ---------------- line buffers ----------------
    median_line_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (IMG_WIDTH)
    ) u_line_buf0 (
        .clk_i   (clk_i),
        .we_i    (store),
        .addr_i  (pos_col),
        .wdata_i (in_data_i),
        .rdata_o (lb0_rdata)
    );

    // Buffer 1 receives the word buffer 0 is about to overwrite.
    median_line_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (IMG_WIDTH)
    ) u_line_buf1 (
        .clk_i   (clk_i),
        .we_i    (store),
        .addr_i  (pos_col),
        .wdata_i (lb0_rdata),
        .rdata_o (lb1_rdata)
    );

    // ---------------- raster counters ----------------
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (store) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
            end else begin
                col_d = pos_col + CW'(1);
                row_d = pos_row;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (restart) state_d = FILL;
            end
            FILL: begin
                if (restart) begin
                    state_d = FILL;
                end else if (store && (pos_row == ROW_TWO) && (pos_col == '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (restart) begin
                    state_d = FILL;
                end else if (store && (pos_row == ROW_LAST) && (pos_col == COL_LAST)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!win_vld_q && !out_valid_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // IDLE is only ever entered with both stages empty, so it can always take
    // a pixel; FLUSH refuses input until the pipeline has drained.
    always_comb begin
        in_ready     = 1'b0;
        frame_done_o = 1'b0;
        busy_o       = (state_q != IDLE);
        case (state_q)
            IDLE:      in_ready = 1'b1;
            FILL, RUN: in_ready = advance;
            FLUSH:     frame_done_o = !win_vld_q && !out_valid_q;
            default:   in_ready = 1'b0;
        endcase
    end

    assign in_ready_o = in_ready;

    // ---------------- window stage ----------------
    // Each stored pixel shifts a new column {buf1, buf0, in} in on the right.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps_q[k] <= '0;
            end
        end else if (store) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                taps_q[tap_idx(r, 0)] <= taps_q[tap_idx(r, 1)];
                taps_q[tap_idx(r, 1)] <= taps_q[tap_idx(r, 2)];
            end
            taps_q[tap_idx(0, 2)] <= lb1_rdata;
            taps_q[tap_idx(1, 2)] <= lb0_rdata;
            taps_q[tap_idx(2, 2)] <= in_data_i;
        end
    end

    // The window flag empties when its word moves on without a replacement.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_vld_q <= 1'b0;
            win_sof_q <= 1'b0;
            win_eol_q <= 1'b0;
        end else if (store || advance) begin
            win_vld_q <= win_ok;
            win_sof_q <= win_ok && (pos_row == ROW_TWO) && (pos_col == COL_TWO);
            win_eol_q <= win_ok && (pos_col == COL_LAST);
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_taps
        assign win_taps_o[k*DATA_SIZE +: DATA_SIZE] = taps_q[k];
    end

    // ---------------- output stage ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else if (advance) begin
            out_valid_q <= win_vld_q;
            out_data_q  <= med_result_i;
            out_sof_q   <= win_sof_q;
            out_eol_q   <= win_eol_q;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sof_o   = out_sof_q;
    assign out_eol_o   = out_eol_q;

endmodule
